// File: rtl/fetch_align.sv
// Instruction realignment buffer: splits 32-bit fetch words into halfword parcels
// and presents whole RV32IMC instructions with their PC. Optional: FETCH_ILLEGAL_CHK_EN.
module fetch_align #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_is_comp_o,
    output logic            instr_illegal_o
);

    logic [3:0][15:0] hw_q, q_nxt;
    logic [2:0]       count_q, count_nxt, n_cons, n_app;
    logic [1:0]       tail;
    logic [XLEN-1:0]  pc_q;
    logic             drop_q;
    logic             comp, consume, accept;

    always_comb begin
        comp          = (hw_q[0][1:0] != 2'b11);
        instr_valid_o = ((count_q != 3'd0) && comp) || ((count_q >= 3'd2) && !comp);
        consume       = instr_valid_o && instr_ready_i;
        fetch_ready_o = (count_q <= 3'd2) && !flush_i;
        accept        = fetch_valid_i && fetch_ready_o;
        n_cons        = consume ? (comp ? 3'd1 : 3'd2) : 3'd0;
        n_app         = accept ? (drop_q ? 3'd1 : 3'd2) : 3'd0;
        count_nxt     = count_q - n_cons + n_app;
        tail          = 2'(count_q - n_cons);

        // Shift out the consumed parcels first; vacated top entries keep stale data.
        unique case (n_cons)
            3'd1:    q_nxt = {hw_q[3], hw_q[3:1]};
            3'd2:    q_nxt = {hw_q[3:2], hw_q[3:2]};
            default: q_nxt = hw_q;
        endcase

        // Append at the post-shift tail; accept implies count <= 2, so tail+1 <= 3.
        if (accept) begin
            if (drop_q) begin
                q_nxt[tail] = fetch_data_i[31:16];
            end else begin
                q_nxt[tail]        = fetch_data_i[15:0];
                q_nxt[tail + 2'd1] = fetch_data_i[31:16];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hw_q    <= '0;
            count_q <= 3'd0;
            pc_q    <= RESET_PC;
            drop_q  <= RESET_PC[1];
        end else if (flush_i) begin
            count_q <= 3'd0;
            pc_q    <= {flush_pc_i[XLEN-1:1], 1'b0};
            drop_q  <= flush_pc_i[1];
        end else begin
            hw_q    <= q_nxt;
            count_q <= count_nxt;
            if (consume) pc_q <= pc_q + (comp ? XLEN'(2) : XLEN'(4));
            if (accept)  drop_q <= 1'b0;
        end
    end

    assign instr_o         = comp ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]};
    assign instr_pc_o      = pc_q;
    // Gated by occupancy so an empty buffer never reports a compressed head.
    assign instr_is_comp_o = (count_q != 3'd0) && comp;

`ifdef FETCH_ILLEGAL_CHK_EN
    assign instr_illegal_o = instr_valid_o && comp && (hw_q[0] == 16'h0000);
`else
    assign instr_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_align.sv
// Scoreboard bench for fetch_align: a parcel-stream parser predicts the instruction
// sequence, a negedge monitor checks every presented instruction and the handshakes.
module tb_fetch_align;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_comp_o;
    logic        instr_illegal_o;

    fetch_align #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_data_i(fetch_data_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_is_comp_o(instr_is_comp_o), .instr_illegal_o(instr_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] par_q[$];
    logic [31:0] spc;
    logic        drop;
    int          occ;
    int          n_vec;
    int          n_bad;
    logic        mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Turns the in-order parcel stream into complete instructions as soon as they exist.
    function automatic void parse();
        exp_t e;
        while (par_q.size() > 0) begin
            if (par_q[0][1:0] != 2'b11) begin
                e.instr = {16'h0000, par_q[0]};
                e.pc    = spc;
                e.comp  = 1'b1;
`ifdef FETCH_ILLEGAL_CHK_EN
                e.ill   = (par_q[0] == 16'h0000);
`else
                e.ill   = 1'b0;
`endif
                exp_q.push_back(e);
                spc = spc + 32'd2;
                void'(par_q.pop_front());
            end else if (par_q.size() >= 2) begin
                e.instr = {par_q[1], par_q[0]};
                e.pc    = spc;
                e.comp  = 1'b0;
                e.ill   = 1'b0;
                exp_q.push_back(e);
                spc = spc + 32'd4;
                void'(par_q.pop_front());
                void'(par_q.pop_front());
            end else begin
                break;
            end
        end
    endfunction

    // Monitor: every cycle checks handshake signals; on a consume, pops and compares.
    always @(negedge clk_i) begin
        if (mon_en) begin
            exp_t e;
            chk("fetch_ready", 32'(fetch_ready_o), 32'((occ <= 2) && !flush_i));
            chk("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
            if (instr_valid_o && instr_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got %h @%h, expected none", instr_o, instr_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", instr_o, e.instr);
                    chk("instr_pc", instr_pc_o, e.pc);
                    chk("is_comp", 32'(instr_is_comp_o), 32'(e.comp));
                    chk("illegal", 32'(instr_illegal_o), 32'(e.ill));
                    occ -= e.comp ? 1 : 2;
                end
            end
        end
    end

    // One clock of stimulus; the model absorbs the cycle's fetch/flush after the monitor ran.
    task automatic step(input logic fv, input logic [31:0] fd, input logic ir,
                        input logic fl, input logic [31:0] fpc);
        fetch_valid_i = fv;
        fetch_data_i  = fd;
        instr_ready_i = ir;
        flush_i       = fl;
        flush_pc_i    = fpc;
        @(negedge clk_i);
        #1;
        if (flush_i) begin
            par_q.delete();
            exp_q.delete();
            occ  = 0;
            spc  = {flush_pc_i[31:1], 1'b0};
            drop = flush_pc_i[1];
        end else if (fetch_valid_i && fetch_ready_o) begin
            if (!drop) par_q.push_back(fetch_data_i[15:0]);
            par_q.push_back(fetch_data_i[31:16]);
            occ += drop ? 1 : 2;
            drop = 1'b0;
            parse();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input logic ir);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, ir, 1'b0, 32'h0);
    endtask

    function automatic logic [15:0] rand_parcel();
        logic [15:0] p;
        p = 16'($urandom);
        if ($urandom_range(0, 15) == 0) p = 16'h0000;
        return p;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        mon_en = 1'b0;
        occ = 0;
        spc = RESET_PC;
        drop = RESET_PC[1];
        rst_ni = 1'b0;
        flush_i = 1'b0;
        flush_pc_i = '0;
        fetch_valid_i = 1'b0;
        fetch_data_i = '0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", instr_pc_o, RESET_PC);
        chk("rst_comp", 32'(instr_is_comp_o), 32'd0);
        chk("rst_illegal", 32'(instr_illegal_o), 32'd0);
        chk("rst_ready", 32'(fetch_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;

        // addi a0,x0,10 at reset PC
        step(1'b1, 32'h00A0_0513, 1'b0, 1'b0, 32'h0);
        idle(2, 1'b1);
        // two c.li
        step(1'b1, 32'h4505_4501, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1);
        // straddle: c.li then a 32-bit op split across words
        step(1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1);
        step(1'b1, 32'hABCD_00A0, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1);
        // back-pressure until full, then release
        for (int i = 0; i < 4; i++) step(1'b1, 32'h4505_4501 + 32'(i << 8), 1'b0, 1'b0, 32'h0);
        idle(8, 1'b1);
        // build count=3 via a misaligned flush, then flush again with a live handshake
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102);
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h4505_4501, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h4509_4501, 1'b1, 1'b1, 32'h8000_0106);
        step(1'b1, 32'h4505_1234, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1);
        // all-zero compressed parcels
        step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1);
        // PC wrap at the top of the address space
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 32'h4505_4501, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0513_4501, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h4505_00A0, 1'b1, 1'b0, 32'h0);
        idle(4, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic        fl;
            logic [31:0] fpc;
            fl  = ($urandom_range(0, 99) < 3);
            fpc = $urandom() & 32'hFFFF_FFFE;
            if ($urandom_range(0, 3) == 0) fpc = 32'hFFFF_FFF0 | (fpc & 32'hE);
            fpc[0] = 1'($urandom);
            step($urandom_range(0, 9) < 7, {rand_parcel(), rand_parcel()},
                 $urandom_range(0, 9) < 7, fl, fpc);
        end

        idle(10, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_align.md
Name: fetch_align

Overview:
- Instruction realignment buffer between the fetch interface and the decode/immediate-extend stage of the RV32IMC core.
- Accepts word-aligned 32-bit fetch words and splits them into 16-bit parcels.
- Presents one complete instruction per handshake (16-bit compressed or 32-bit, possibly straddling two fetch words), with its PC, to decode.
- Tracks the instruction PC internally and handles redirects (flush) to halfword-aligned targets.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h8000_0000, PC of the first instruction after reset; bit 0 must be 0.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  redirect; discards all buffered parcels.
- flush_pc_i  input  XLEN  redirect target; bit 0 ignored.
- fetch_valid_i  input  1  fetch word valid.
- fetch_ready_o  output  1  aligner can accept a fetch word.
- fetch_data_i  input  32  fetch word; [15:0] = lower-address halfword.
- instr_valid_o  output  1  complete instruction at head.
- instr_ready_i  input  1  decode consumes the head instruction.
- instr_o  output  32  instruction; compressed ones zero-extended in [31:16].
- instr_pc_o  output  XLEN  PC of instr_o.
- instr_is_comp_o  output  1  head is 16-bit (hw0[1:0] != 2'b11).
- instr_illegal_o  output  1  see Optional Feature.

Behaviour:
- Storage is a 4-entry halfword queue hw0..hw3, with a count 0..4, a head PC register, and a drop_first flag.
- Reset state: count=0, pc=RESET_PC, drop_first=RESET_PC[1].
  - All outputs are derived from registers, so after reset: instr_valid_o=0, instr_o=0, instr_pc_o=RESET_PC, instr_is_comp_o=0, instr_illegal_o=0, fetch_ready_o=1.
- fetch_ready_o = (count <= 2) && !flush_i.
- Accept = fetch_valid_i && fetch_ready_o.
  - drop_first=0: append both halfwords (count += 2).
  - drop_first=1: append only [31:16] (count += 1), then clear drop_first.
- Head instruction:
  - comp = (hw0[1:0] != 2'b11).
  - instr_valid_o = (count >= 1 && comp) || (count >= 2 && !comp).
  - instr_o = comp ? {16'h0, hw0} : {hw1, hw0}.
- Consume = instr_valid_o && instr_ready_i.
  - Shift the queue by 1 (comp) or 2 halfwords.
  - pc += 2 (comp) or 4, modulo 2^XLEN (wrap allowed).
- Simultaneous accept and consume in one cycle: shift first, then append at the new tail. count_next = count − consumed + appended; never exceeds 4.
- Latency: a word accepted in cycle N can be presented in cycle N+1 at the earliest.
- Straddling 32-bit instruction (only hw0 present, not compressed): instr_valid_o stays 0 until the next word arrives.
- flush_i has priority over accept and consume in the same cycle.
  - Next state: count=0, pc={flush_pc_i[XLEN-1:1],1'b0}, drop_first=flush_pc_i[1].
  - A handshake in the flush cycle has no effect on state.
  - fetch_ready_o=0 during the flush cycle.
- Reset asserted mid-operation: immediately returns to the reset state; buffered parcels are lost.
- Unused queue entries hold stale data; they are not required to be zero.

Optional Feature:
- Macro: FETCH_ILLEGAL_CHK_EN.
- Defined: instr_illegal_o = instr_valid_o && comp && (hw0 == 16'h0000), i.e. the defined-illegal all-zero compressed parcel. Decode uses it to raise an illegal-instruction exception.
- Not defined: instr_illegal_o is tied to 0 and no compare logic is built.

Test Plan:
- Reset, then feed 32'h00A0_0513 (addi a0,x0,10) at RESET_PC -> one cycle later: instr_valid_o=1, instr_o=32'h00A00513, instr_pc_o=32'h8000_0000, instr_is_comp_o=0.
- Feed word 32'h4505_4501 (two c.li) with decode always ready -> 16'h4501 @0x8000_0000, then 16'h4505 @0x8000_0002, both comp=1.
- Straddle: word 32'h0513_4501 then 32'hxxxx_00A0 -> c.li @0x8000_0000, then instr_o=32'h00A00513 @0x8000_0002 only after the second word is accepted.
- Back-pressure: instr_ready_i=0, push compressed words until count=4 -> fetch_ready_o=0. Release -> no parcel lost or duplicated, PCs increment by 2.
- flush_i with flush_pc_i=32'h8000_0106 while count=3, then feed 32'h4505_1234 -> only 16'h4505 is presented, at pc 0x8000_0106. The flush-cycle handshake is ignored.
- With FETCH_ILLEGAL_CHK_EN defined, feed 32'h0000_0000 -> instr_illegal_o=1, comp=1. Without the macro -> instr_illegal_o=0.
